// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU control path: opcodes, ALU codes,
// sequencer state encoding, IR field positions and the control-word layout.
package mini_cpu_pkg;

  localparam int OPW   = 5;
  localparam int STEPW = 4;

  // IR field positions
  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;
  localparam int IR_C2_MSB = 20;
  localparam int IR_C2_LSB = 19;

  // Opcodes
  localparam logic [OPW-1:0] OP_LD   = 5'd0;
  localparam logic [OPW-1:0] OP_LDI  = 5'd1;
  localparam logic [OPW-1:0] OP_ST   = 5'd2;
  localparam logic [OPW-1:0] OP_ADD  = 5'd3;
  localparam logic [OPW-1:0] OP_SUB  = 5'd4;
  localparam logic [OPW-1:0] OP_AND  = 5'd5;
  localparam logic [OPW-1:0] OP_OR   = 5'd6;
  localparam logic [OPW-1:0] OP_SHR  = 5'd7;
  localparam logic [OPW-1:0] OP_SHRA = 5'd8;
  localparam logic [OPW-1:0] OP_SHL  = 5'd9;
  localparam logic [OPW-1:0] OP_ROR  = 5'd10;
  localparam logic [OPW-1:0] OP_ROL  = 5'd11;
  localparam logic [OPW-1:0] OP_ADDI = 5'd12;
  localparam logic [OPW-1:0] OP_ANDI = 5'd13;
  localparam logic [OPW-1:0] OP_ORI  = 5'd14;
  localparam logic [OPW-1:0] OP_MUL  = 5'd15;
  localparam logic [OPW-1:0] OP_DIV  = 5'd16;
  localparam logic [OPW-1:0] OP_NEG  = 5'd17;
  localparam logic [OPW-1:0] OP_NOT  = 5'd18;
  localparam logic [OPW-1:0] OP_BRX  = 5'd19;
  localparam logic [OPW-1:0] OP_JR   = 5'd20;
  localparam logic [OPW-1:0] OP_IN   = 5'd22;
  localparam logic [OPW-1:0] OP_OUT  = 5'd23;
  localparam logic [OPW-1:0] OP_MFHI = 5'd24;
  localparam logic [OPW-1:0] OP_MFLO = 5'd25;
  localparam logic [OPW-1:0] OP_NOP  = 5'd26;
  localparam logic [OPW-1:0] OP_HALT = 5'd27;

  // ALU operation codes; zero means "no operation requested"
  localparam logic [4:0] ALU_NONE = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_SHR  = 5'd5;
  localparam logic [4:0] ALU_SHRA = 5'd6;
  localparam logic [4:0] ALU_SHL  = 5'd7;
  localparam logic [4:0] ALU_ROR  = 5'd8;
  localparam logic [4:0] ALU_ROL  = 5'd9;
  localparam logic [4:0] ALU_MUL  = 5'd10;
  localparam logic [4:0] ALU_DIV  = 5'd11;
  localparam logic [4:0] ALU_NEG  = 5'd12;
  localparam logic [4:0] ALU_NOT  = 5'd13;

  typedef enum logic [STEPW-1:0] {
    RESET_S = 4'd0,
    T0      = 4'd1,
    T1      = 4'd2,
    T2      = 4'd3,
    T3      = 4'd4,
    T4      = 4'd5,
    T5      = 4'd6,
    T6      = 4'd7,
    T7      = 4'd8,
    HALT_S  = 4'd9
  } state_t;

  // Instructions sharing one execute sequence are grouped into a class
  typedef enum logic [3:0] {
    CLS_ALU, CLS_IMM, CLS_MULDIV, CLS_UNARY, CLS_LD, CLS_LDI, CLS_ST, CLS_BRX,
    CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
  } op_class_t;

  typedef struct packed {
    logic       pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, inport_out,
                c_out, ba_out, r_out;
    logic       mar_in, pc_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
                outport_in, con_in, r_in;
    logic       gra, grb, grc;
    logic       inc_pc, read, write;
    logic [4:0] alu_op;
  } ctrl_t;

  function automatic op_class_t op_class(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL:          return CLS_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:        return CLS_IMM;
      OP_MUL, OP_DIV:                  return CLS_MULDIV;
      OP_NEG, OP_NOT:                  return CLS_UNARY;
      OP_LD:                           return CLS_LD;
      OP_LDI:                          return CLS_LDI;
      OP_ST:                           return CLS_ST;
      OP_BRX:                          return CLS_BRX;
      OP_JR:                           return CLS_JR;
      OP_IN:                           return CLS_IN;
      OP_OUT:                          return CLS_OUT;
      OP_MFHI:                         return CLS_MFHI;
      OP_MFLO:                         return CLS_MFLO;
      OP_HALT:                         return CLS_HALT;
      default:                         return CLS_NOP;
    endcase
  endfunction

  // Final execute step of each class; the sequencer returns to T0 after it
  function automatic state_t last_step(input op_class_t cls);
    case (cls)
      CLS_ALU, CLS_IMM, CLS_LDI:       return T5;
      CLS_MULDIV, CLS_ST, CLS_BRX:     return T6;
      CLS_UNARY:                       return T4;
      CLS_LD:                          return T7;
      default:                         return T3;
    endcase
  endfunction

  // ALU code for the step that loads Z; address arithmetic always adds
  function automatic logic [4:0] alu_for(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST, OP_BRX: return ALU_ADD;
      OP_SUB:                                        return ALU_SUB;
      OP_AND, OP_ANDI:                               return ALU_AND;
      OP_OR, OP_ORI:                                 return ALU_OR;
      OP_SHR:                                        return ALU_SHR;
      OP_SHRA:                                       return ALU_SHRA;
      OP_SHL:                                        return ALU_SHL;
      OP_ROR:                                        return ALU_ROR;
      OP_ROL:                                        return ALU_ROL;
      OP_MUL:                                        return ALU_MUL;
      OP_DIV:                                        return ALU_DIV;
      OP_NEG:                                        return ALU_NEG;
      OP_NOT:                                        return ALU_NOT;
      default:                                       return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cs_step_counter.sv
// Sequencer state register and next-state logic: fetch T0-T2, an
// opcode-dependent execute length, halt on request, synchronous clear.
module cs_step_counter
  import mini_cpu_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic             stop,
  input  logic [OPW-1:0]   opcode,
  output logic [STEPW-1:0] step
);

  state_t    state_q;
  state_t    state_n;
  op_class_t cls;

  assign cls  = op_class(opcode);
  assign step = state_q;

  // Next-state selection; clear is applied in the register so it wins over everything
  always_comb begin
    // NOTE: default first so every path assigns state_n and no latch is inferred
    state_n = state_q;
    case (state_q)
      RESET_S: state_n = T0;
      T0:      state_n = stop ? HALT_S : T1;
      T1:      state_n = T2;
      T2:      state_n = T3;
      HALT_S:  state_n = HALT_S;
      default: begin
        if (state_q == T3 && cls == CLS_HALT) begin
          state_n = HALT_S;
        end else if (state_q == last_step(cls)) begin
          state_n = T0;
        end else begin
          state_n = state_t'(state_q + 4'd1);
        end
      end
    endcase
  end

  // State register with synchronous active-high clear
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so all state updates see pre-edge values
    if (clear) begin
      state_q <= RESET_S;
    end else begin
      state_q <= state_n;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the mini CPU: Moore decode of (step, opcode)
// into every datapath control line.
module control_sequencer
  import mini_cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
  output logic        MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin, Rin,
  output logic        Gra, Grb, Grc,
  output logic        IncPC, Read, Write,
  output logic [4:0]  alu_op
);

  logic [OPW-1:0]   opcode;
  logic [STEPW-1:0] step;
  state_t           state;
  op_class_t        cls;
  ctrl_t            c;
  logic             ir_unused;

  assign opcode    = ir[IR_OP_MSB:IR_OP_LSB];
  assign ir_unused = ^ir[IR_OP_LSB-1:0];
  assign state     = state_t'(step);
  assign cls       = op_class(opcode);

  cs_step_counter u_step (
    .clk    (Clock),
    .clear  (clear),
    .stop   (stop),
    .opcode (opcode),
    .step   (step)
  );

  // Control-word decode for the current step and instruction class
  always_comb begin
    c = '0;
    case (state)
      T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
      T1: begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
      T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      T3: case (cls)
        CLS_ALU, CLS_IMM:       begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
        CLS_MULDIV:             begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
        CLS_UNARY:              begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1;
                                      c.alu_op = alu_for(opcode); end
        CLS_LD, CLS_LDI, CLS_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
        CLS_BRX:                begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
        CLS_JR:                 begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
        CLS_IN:                 begin c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
        CLS_OUT:                begin c.gra = 1'b1; c.r_out = 1'b1; c.outport_in = 1'b1; end
        CLS_MFHI:               begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
        CLS_MFLO:               begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
        default:                ;
      endcase
      T4: case (cls)
        CLS_ALU:                begin c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1;
                                      c.alu_op = alu_for(opcode); end
        CLS_MULDIV:             begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1;
                                      c.alu_op = alu_for(opcode); end
        CLS_IMM, CLS_LD, CLS_LDI, CLS_ST:
                                begin c.c_out = 1'b1; c.z_in = 1'b1;
                                      c.alu_op = alu_for(opcode); end
        CLS_UNARY:              begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
        CLS_BRX:                begin c.pc_out = 1'b1; c.y_in = 1'b1; end
        default:                ;
      endcase
      T5: case (cls)
        CLS_ALU, CLS_IMM, CLS_LDI: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
        CLS_MULDIV:             begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
        CLS_LD, CLS_ST:         begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
        CLS_BRX:                begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = alu_for(opcode); end
        default:                ;
      endcase
      T6: case (cls)
        CLS_MULDIV:             begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
        CLS_LD:                 begin c.read = 1'b1; c.mdr_in = 1'b1; end
        CLS_ST:                 begin c.gra = 1'b1; c.r_out = 1'b1; c.write = 1'b1; end
        CLS_BRX:                begin c.zlow_out = con_ff; c.pc_in = con_ff; end
        default:                ;
      endcase
      T7: if (cls == CLS_LD) begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      default: ;
    endcase
  end

  assign run       = (state != RESET_S) && (state != HALT_S);
  assign PCout     = c.pc_out;
  assign Zhighout  = c.zhigh_out;
  assign Zlowout   = c.zlow_out;
  assign MDRout    = c.mdr_out;
  assign HIout     = c.hi_out;
  assign LOout     = c.lo_out;
  assign InPortout = c.inport_out;
  assign Cout      = c.c_out;
  assign BAout     = c.ba_out;
  assign Rout      = c.r_out;
  assign MARin     = c.mar_in;
  assign PCin      = c.pc_in;
  assign MDRin     = c.mdr_in;
  assign IRin      = c.ir_in;
  assign Yin       = c.y_in;
  assign Zin       = c.z_in;
  assign HIin      = c.hi_in;
  assign LOin      = c.lo_in;
  assign OutPortin = c.outport_in;
  assign CONin     = c.con_in;
  assign Rin       = c.r_in;
  assign Gra       = c.gra;
  assign Grb       = c.grb;
  assign Grc       = c.grc;
  assign IncPC     = c.inc_pc;
  assign Read      = c.read;
  assign Write     = c.write;
  assign alu_op    = c.alu_op;

  // The shared bus may have at most one driver in any step
  bus_single_driver_a: assert property (@(posedge Clock)
    $onehot0({PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout}));

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus random instructions,
// each checked cycle by cycle against a per-instruction expected control script.
module tb_control_sequencer;
  import mini_cpu_pkg::*;

  typedef logic [32:0] vec_t;

  localparam vec_t PCOUT     = 33'd1 << 0;
  localparam vec_t ZHIGHOUT  = 33'd1 << 1;
  localparam vec_t ZLOWOUT   = 33'd1 << 2;
  localparam vec_t MDROUT    = 33'd1 << 3;
  localparam vec_t HIOUT     = 33'd1 << 4;
  localparam vec_t LOOUT     = 33'd1 << 5;
  localparam vec_t INPORTOUT = 33'd1 << 6;
  localparam vec_t COUT      = 33'd1 << 7;
  localparam vec_t BAOUT     = 33'd1 << 8;
  localparam vec_t ROUT      = 33'd1 << 9;
  localparam vec_t MARIN     = 33'd1 << 10;
  localparam vec_t PCIN      = 33'd1 << 11;
  localparam vec_t MDRIN     = 33'd1 << 12;
  localparam vec_t IRIN      = 33'd1 << 13;
  localparam vec_t YIN       = 33'd1 << 14;
  localparam vec_t ZIN       = 33'd1 << 15;
  localparam vec_t HIIN      = 33'd1 << 16;
  localparam vec_t LOIN      = 33'd1 << 17;
  localparam vec_t OUTPORTIN = 33'd1 << 18;
  localparam vec_t CONIN     = 33'd1 << 19;
  localparam vec_t RIN       = 33'd1 << 20;
  localparam vec_t GRA       = 33'd1 << 21;
  localparam vec_t GRB       = 33'd1 << 22;
  localparam vec_t GRC       = 33'd1 << 23;
  localparam vec_t INCPC     = 33'd1 << 24;
  localparam vec_t READ      = 33'd1 << 25;
  localparam vec_t WRITE     = 33'd1 << 26;
  localparam vec_t RUN       = 33'd1 << 27;
  localparam vec_t IDLE      = 33'd0;
  localparam vec_t FETCH0    = RUN | PCOUT | MARIN | INCPC | ZIN;
  localparam vec_t FETCH1    = RUN | ZLOWOUT | PCIN | READ | MDRIN;
  localparam vec_t FETCH2    = RUN | MDROUT | IRIN;

  logic        clk = 1'b0;
  logic        clear, con_ff, stop;
  logic [31:0] ir;
  logic        run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic        MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin, Rin;
  logic        Gra, Grb, Grc, IncPC, Read, Write;
  logic [4:0]  alu_op;
  vec_t        obs;
  vec_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .Clock(clk), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop), .run(run),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
    .Rout(Rout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CONin(CONin),
    .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read),
    .Write(Write), .alu_op(alu_op)
  );

  assign obs = {alu_op, run, Write, Read, IncPC, Grc, Grb, Gra, Rin, CONin, OutPortin,
                LOin, HIin, Zin, Yin, IRin, MDRin, PCin, MARin, Rout, BAout, Cout,
                InPortout, LOout, HIout, MDRout, Zlowout, Zhighout, PCout};

  function automatic vec_t alu(input logic [4:0] a);
    return vec_t'(a) << 28;
  endfunction

  // Which ALU operation each opcode asks for when Z is loaded
  function automatic logic [4:0] ref_alu(input int op);
    case (op)
      0, 1, 2, 3, 12, 19: return ALU_ADD;
      4:                  return ALU_SUB;
      5, 13:              return ALU_AND;
      6, 14:              return ALU_OR;
      7:                  return ALU_SHR;
      8:                  return ALU_SHRA;
      9:                  return ALU_SHL;
      10:                 return ALU_ROR;
      11:                 return ALU_ROL;
      15:                 return ALU_MUL;
      16:                 return ALU_DIV;
      17:                 return ALU_NEG;
      18:                 return ALU_NOT;
      default:            return ALU_NONE;
    endcase
  endfunction

  // Expected execute-phase script (T3 onward) for one instruction
  task automatic build_exec(input int op, input bit con);
    vec_t a;
    a = alu(ref_alu(op));
    case (op)
      3, 4, 5, 6, 7, 8, 9, 10, 11:
        exp_q = '{GRB | ROUT | YIN, GRC | ROUT | ZIN | a, ZLOWOUT | GRA | RIN};
      12, 13, 14:
        exp_q = '{GRB | ROUT | YIN, COUT | ZIN | a, ZLOWOUT | GRA | RIN};
      15, 16:
        exp_q = '{GRA | ROUT | YIN, GRB | ROUT | ZIN | a, ZLOWOUT | LOIN, ZHIGHOUT | HIIN};
      17, 18:
        exp_q = '{GRB | ROUT | ZIN | a, ZLOWOUT | GRA | RIN};
      0:
        exp_q = '{GRB | BAOUT | YIN, COUT | ZIN | a, ZLOWOUT | MARIN, READ | MDRIN,
                  MDROUT | GRA | RIN};
      1:
        exp_q = '{GRB | BAOUT | YIN, COUT | ZIN | a, ZLOWOUT | GRA | RIN};
      2:
        exp_q = '{GRB | BAOUT | YIN, COUT | ZIN | a, ZLOWOUT | MARIN, GRA | ROUT | WRITE};
      19:
        exp_q = '{GRA | ROUT | CONIN, PCOUT | YIN, COUT | ZIN | a,
                  con ? (ZLOWOUT | PCIN) : IDLE};
      20: exp_q = '{GRA | ROUT | PCIN};
      22: exp_q = '{INPORTOUT | GRA | RIN};
      23: exp_q = '{GRA | ROUT | OUTPORTIN};
      24: exp_q = '{HIOUT | GRA | RIN};
      25: exp_q = '{LOOUT | GRA | RIN};
      default: exp_q = '{IDLE};
    endcase
    foreach (exp_q[i]) exp_q[i] = exp_q[i] | RUN;
  endtask

  task automatic check(input string tag, input vec_t got, input vec_t want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in T0 and checks every step through the next T0
  task automatic run_instr(input logic [31:0] iw, input bit con, input string tag);
    int op;
    op     = int'(iw[31:27]);
    ir     = $urandom;
    con_ff = con;
    build_exec(op, con);
    step(); check({tag, "/T1"}, obs, FETCH1);
    step(); check({tag, "/T2"}, obs, FETCH2);
    ir = iw;
    foreach (exp_q[i]) begin
      step();
      check($sformatf("%s/T%0d", tag, i + 3), obs, exp_q[i]);
    end
    step();
    check({tag, "/end"}, obs, (op == 27) ? IDLE : FETCH0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op;
    clear = 1'b1; stop = 1'b0; con_ff = 1'b0; ir = 32'h0;

    // Reset: held two cycles, then released into fetch
    step(); check("reset1", obs, IDLE);
    step(); check("reset2", obs, IDLE);
    clear = 1'b0;
    step(); check("reset_to_t0", obs, FETCH0);

    // Directed instructions
    run_instr(32'h18918000, 1'b0, "add");
    run_instr(32'h00900055, 1'b0, "ld");
    run_instr(32'h98100005, 1'b1, "brpl_taken");
    run_instr(32'h98100005, 1'b0, "brpl_not_taken");

    // Random instruction stream, halt excluded
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 31));
      if (op == 27) op = 26;
      run_instr({op[4:0], 27'($urandom)}, 1'($urandom), $sformatf("rnd%0d_op%0d", n, op));
    end

    // Stop request in T0 halts; only clear leaves HALT_S
    stop = 1'b1;
    step(); check("stop_halt", obs, IDLE);
    stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ir = $urandom; con_ff = 1'($urandom);
      step(); check($sformatf("stop_hold%0d", i), obs, IDLE);
    end
    clear = 1'b1;
    step(); check("stop_clear", obs, IDLE);
    clear = 1'b0;
    step(); check("stop_restart", obs, FETCH0);

    // Halt instruction, held ten cycles, then clear
    run_instr(32'hD8000000, 1'b0, "halt");
    for (int i = 0; i < 10; i++) begin
      ir = $urandom; con_ff = 1'($urandom); stop = 1'($urandom);
      step(); check($sformatf("halt_hold%0d", i), obs, IDLE);
    end
    stop = 1'b0;
    clear = 1'b1;
    step(); check("halt_clear", obs, IDLE);
    clear = 1'b0;
    step(); check("halt_restart", obs, FETCH0);

    // Clear in T5 of st aborts before Write
    ir = 32'h10900010;
    build_exec(2, 1'b0);
    step(); check("st_abort/T1", obs, FETCH1);
    step(); check("st_abort/T2", obs, FETCH2);
    for (int i = 0; i < 3; i++) begin
      step(); check($sformatf("st_abort/T%0d", i + 3), obs, exp_q[i]);
    end
    clear = 1'b1;
    step(); check("st_abort/reset", obs, IDLE);
    clear = 1'b0;
    step(); check("st_abort/t0", obs, FETCH0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
